fft_ctrl: RTL and testbench
===========================

FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter BF_LAT, default 2, is the butterfly datapath latency in cycles from G/H read address to X/Y result valid.
REQ-002 Parameter LOG2N, default 5, sets the FFT size to N=32 points, giving 5-bit addresses and 16 butterflies per stage.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 clear  in  1  asynchronous reset, active low.
REQ-005 start  in  1  one-cycle pulse; begins a transform when idle.
REQ-006 in_valid  in  1  one input sample is present on the MEM data_real_in/data_imag_in bus this cycle.
REQ-007 load_data_write  out  1  MEM load-path select and bank0 port-A write.
REQ-008 load_data_addr  out  5  MEM load address.
REQ-009 bank0_write_en, bank1_write_en  out  1 each  bank write strobes for butterfly write-back.
REQ-010 rw_addr_en  out  1  0 = read addresses valid; 1 = write addresses applied on the bank being written.
REQ-011 bank_read_sel  out  1  selects the bank that supplies G/H: 0 = bank0, 1 = bank1.
REQ-012 read_G_addr, read_H_addr, write_G_addr, write_H_addr  out  5 each  butterfly pair addresses.
REQ-013 twiddle_addr  out  4  twiddle ROM index for the butterfly currently being read.
REQ-014 out_valid  out  1  unload read is active this cycle.
REQ-015 out_index  out  5  natural-order frequency bin of the current unload read.
REQ-016 busy, done  out  1 each  busy is high outside IDLE; done is a one-cycle pulse at the end of UNLOAD.

Function
REQ-017 FSM states are IDLE, LOAD, STAGE, DRAIN and UNLOAD.
REQ-018 IDLE->LOAD on start; start is ignored in every other state.
REQ-019 LOAD: load_data_write = in_valid; load_data_addr = load counter, which advances only on in_valid.
REQ-020 LOAD->STAGE when the 32nd accepted sample is written (counter 31 with in_valid); stage s=0 and bank_read_sel=0.
REQ-021 STAGE s (0..4), butterfly counter b (0..15), one read per cycle.
REQ-022 STAGE address rule: read_G_addr = b with a 0 inserted at bit (4-s); read_H_addr = read_G_addr | (1<<(4-s)).
REQ-023 STAGE twiddle rule: twiddle_addr = (b << s) mod 16, decimation in frequency.
REQ-024 write_G_addr/write_H_addr equal the read addresses delayed BF_LAT+1 cycles; the write strobe of bank (1-bank_read_sel) is asserted in the same cycles, the other strobe stays 0.
REQ-025 STAGE->DRAIN after b=15 issues; DRAIN lasts BF_LAT+1 cycles so all writes complete.
REQ-026 DRAIN end with s<4: s increments, bank_read_sel toggles, return to STAGE; with s=4: bank_read_sel toggles, go to UNLOAD.
REQ-027 Stages never overlap; no read of stage s+1 is issued before the last write of stage s.
REQ-028 UNLOAD: 32 cycles, out_index counts 0..31; read_G_addr = bit-reverse(out_index); out_valid high, delayed to align with the MEM read latency of 1.
REQ-029 UNLOAD end pulses done for one cycle and returns to IDLE.
REQ-030 All counters wrap modulo their range; wrap is never reached mid-phase.
REQ-031 in_valid outside LOAD is ignored.

Reset
REQ-032 clear low forces IDLE asynchronously, from any state including mid-stage.
REQ-033 On clear low, all counters, s and bank_read_sel go to 0.
REQ-034 On clear low, all strobes, busy, done and out_valid go to 0 and all addresses go to 0.
REQ-035 The first start after clear is honoured on the cycle after release.

Structure
REQ-036 A shared package holds the state enum, LOG2N, N, N/2 and the bit-reverse function.
REQ-037 The write-address/strobe delay line is a single sub-module, fft_ctrl_wb_delay, with depth BF_LAT+1.

Verification
REQ-038 Contiguous load: start, then in_valid for 32 cycles -> load_data_addr 0..31, STAGE entered the next cycle.
REQ-039 Gapped load: in_valid every other cycle -> exactly 32 writes, addresses unchanged during gaps.
REQ-040 Stage 2, b=5 -> read_G=9, read_H=13, twiddle=4; the matching write appears BF_LAT+1 cycles later on bank1.
REQ-041 Full run with BF_LAT=2 -> total latency is 32 + 5*(16+3) + 32 cycles from first sample to done, and bank_read_sel=1 in UNLOAD.
REQ-042 UNLOAD addressing -> out_index=1 reads address 16 and out_index=6 reads address 12.
REQ-043 clear asserted in stage 3 -> outputs 0 immediately; a new start runs a full correct transform.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT address/sequence controller: sizes,
// FSM state encoding and the bit-reverse helper used for output ordering.
package fft_ctrl_pkg;

    localparam int FFT_LOG2N  = 5;
    localparam int FFT_N      = 1 << FFT_LOG2N;
    localparam int FFT_HALF_N = FFT_N / 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STAGE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_UNLOAD = 3'd4
    } state_e;

    // Reverse the low 'width' bits of v; bits above 'width' come back as 0.
    // Implemented as a shift so no variable bit-select is needed.
    function automatic logic [15:0] bit_reverse(input logic [15:0] v, input int width);
        logic [15:0] src;
        logic [15:0] res;
        src = v;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                res = {res[14:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_ctrl_wb_delay.sv
// Write-back delay line: carries the butterfly read addresses and a valid
// flag forward by DEPTH cycles so they line up with the datapath result.
module fft_ctrl_wb_delay #(
    parameter int DEPTH = 3,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          valid_i,
    input  logic [AW-1:0] g_addr_i,
    input  logic [AW-1:0] h_addr_i,
    output logic          valid_o,
    output logic [AW-1:0] g_addr_o,
    output logic [AW-1:0] h_addr_o
);

    localparam int TW = 1 + 2 * AW;

    logic [TW-1:0] tap_in;
    assign tap_in = {valid_i, g_addr_i, h_addr_i};

    // One register per tap; each tap copies its predecessor every cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
        logic [TW-1:0] tap_q;
        if (gi == 0) begin : g_first
            // First tap samples the live read addresses.
            always_ff @(posedge clk or negedge clear) begin
                if (!clear) tap_q <= '0;
                else        tap_q <= tap_in;
            end
        end else begin : g_rest
            // Later taps shift the previous tap along.
            always_ff @(posedge clk or negedge clear) begin
                if (!clear) tap_q <= '0;
                else        tap_q <= g_tap[gi-1].tap_q;
            end
        end
    end

    assign {valid_o, g_addr_o, h_addr_o} = g_tap[DEPTH-1].tap_q;

endmodule

// File: rtl/fft_ctrl.sv
// Radix-2 DIF FFT sequencer: loads N samples, runs LOG2N butterfly stages
// ping-ponging between two banks, then unloads in natural frequency order.
module fft_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int BF_LAT = 2,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             in_valid,
    output logic             load_data_write,
    output logic [LOG2N-1:0] load_data_addr,
    output logic             bank0_write_en,
    output logic             bank1_write_en,
    output logic             rw_addr_en,
    output logic             bank_read_sel,
    output logic [LOG2N-1:0] read_G_addr,
    output logic [LOG2N-1:0] read_H_addr,
    output logic [LOG2N-1:0] write_G_addr,
    output logic [LOG2N-1:0] write_H_addr,
    output logic [LOG2N-2:0] twiddle_addr,
    output logic             out_valid,
    output logic [LOG2N-1:0] out_index,
    output logic             busy,
    output logic             done
);

    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int DW = $clog2(BF_LAT + 2);

    localparam logic [LOG2N-1:0] A_ONE      = LOG2N'(1);
    localparam logic [LOG2N-1:0] A_LAST     = '1;
    localparam logic [LOG2N-2:0] B_ONE      = (LOG2N-1)'(1);
    localparam logic [LOG2N-2:0] B_LAST     = '1;
    localparam logic [SW-1:0]    S_ONE      = SW'(1);
    localparam logic [SW-1:0]    S_LAST     = SW'(LOG2N - 1);
    localparam logic [DW-1:0]    D_ONE      = DW'(1);
    localparam logic [DW-1:0]    D_LAST     = DW'(BF_LAT);

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   load_cnt_q, load_cnt_d;
    logic [LOG2N-2:0]   bfly_q, bfly_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [LOG2N-1:0]   unload_q, unload_d;
    logic               bank_q, bank_d;
    logic               out_valid_q;
    logic               done_q;

    // Butterfly pair addresses for the current stage: a zero is spliced
    // into the butterfly index at bit ins_pos, the partner sets that bit.
    logic [SW-1:0]      ins_pos;
    logic [LOG2N-1:0]   b_ext, hi_bit, low_mask, stage_g, stage_h;
    logic [LOG2N-2:0]   stage_tw;
    logic [LOG2N-1:0]   unload_rev;
    logic               rd_valid;
    logic [LOG2N-1:0]   wb_g_in, wb_h_in;
    logic               wb_valid;

    assign ins_pos    = S_LAST - stage_q;
    assign b_ext      = {1'b0, bfly_q};
    assign hi_bit     = A_ONE << ins_pos;
    assign low_mask   = hi_bit - A_ONE;
    assign stage_g    = ((b_ext >> ins_pos) << (ins_pos + S_ONE)) | (b_ext & low_mask);
    assign stage_h    = stage_g | hi_bit;
    assign stage_tw   = bfly_q << stage_q;
    assign unload_rev = LOG2N'(bit_reverse(16'(unload_q), LOG2N));

    assign rd_valid = (state_q == ST_STAGE);
    assign wb_g_in  = rd_valid ? stage_g : '0;
    assign wb_h_in  = rd_valid ? stage_h : '0;

    fft_ctrl_wb_delay #(
        .DEPTH (BF_LAT + 1),
        .AW    (LOG2N)
    ) u_wb_delay (
        .clk      (clk),
        .clear    (clear),
        .valid_i  (rd_valid),
        .g_addr_i (wb_g_in),
        .h_addr_i (wb_h_in),
        .valid_o  (wb_valid),
        .g_addr_o (write_G_addr),
        .h_addr_o (write_H_addr)
    );

    // State, counters and the registered unload/done flags.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= '0;
            bfly_q      <= '0;
            stage_q     <= '0;
            drain_q     <= '0;
            unload_q    <= '0;
            bank_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            bfly_q      <= bfly_d;
            stage_q     <= stage_d;
            drain_q     <= drain_d;
            unload_q    <= unload_d;
            bank_q      <= bank_d;
            out_valid_q <= (state_q == ST_UNLOAD);
            done_q      <= (state_q == ST_UNLOAD) && (unload_q == A_LAST);
        end
    end

    // Phase sequencing: load -> (stage, drain) x LOG2N -> unload -> idle.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        bfly_d     = bfly_q;
        stage_d    = stage_q;
        drain_d    = drain_q;
        unload_d   = unload_q;
        bank_d     = bank_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    load_cnt_d = load_cnt_q + A_ONE;
                    if (load_cnt_q == A_LAST) begin
                        state_d = ST_STAGE;
                        stage_d = '0;
                        bank_d  = 1'b0;
                        bfly_d  = '0;
                    end
                end
            end
            ST_STAGE: begin
                bfly_d = bfly_q + B_ONE;
                if (bfly_q == B_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                // Hold off the next stage until the last write-back lands.
                drain_d = drain_q + D_ONE;
                if (drain_q == D_LAST) begin
                    drain_d = '0;
                    bank_d  = ~bank_q;
                    if (stage_q == S_LAST) begin
                        state_d  = ST_UNLOAD;
                        unload_d = '0;
                    end else begin
                        state_d = ST_STAGE;
                        stage_d = stage_q + S_ONE;
                    end
                end
            end
            ST_UNLOAD: begin
                unload_d = unload_q + A_ONE;
                if (unload_q == A_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs decoded from the current phase.
    always_comb begin
        load_data_write = 1'b0;
        load_data_addr  = '0;
        read_G_addr     = '0;
        read_H_addr     = '0;
        twiddle_addr    = '0;
        out_index       = '0;
        case (state_q)
            ST_LOAD: begin
                load_data_write = in_valid;
                load_data_addr  = load_cnt_q;
            end
            ST_STAGE: begin
                read_G_addr  = stage_g;
                read_H_addr  = stage_h;
                twiddle_addr = stage_tw;
            end
            ST_UNLOAD: begin
                read_G_addr = unload_rev;
                out_index   = unload_q;
            end
            default: ;
        endcase
    end

    // Results go to the bank not being read this stage.
    assign bank0_write_en = wb_valid & bank_q;
    assign bank1_write_en = wb_valid & ~bank_q;
    assign rw_addr_en     = wb_valid;
    assign bank_read_sel  = bank_q;
    assign out_valid      = out_valid_q;
    assign done           = done_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: a schedule model predicts every output
// per cycle from the transform's phase timeline; scenarios check it.
module tb_fft_ctrl;

    localparam int BF_LAT    = 2;
    localparam int LOG2N     = 5;
    localparam int N         = 32;
    localparam int HALF      = 16;
    localparam int STAGE_LEN = HALF + BF_LAT + 1;
    localparam int MAXC      = 640;
    localparam int NF        = 15;

    localparam int F_LW = 0, F_LA = 1, F_RG = 2, F_RH = 3, F_TW = 4, F_B0 = 5, F_B1 = 6,
                   F_RW = 7, F_WG = 8, F_WH = 9, F_OV = 10, F_OI = 11, F_BUSY = 12,
                   F_DONE = 13, F_BANK = 14;

    logic             clk, clear, start, in_valid;
    logic             load_data_write;
    logic [LOG2N-1:0] load_data_addr;
    logic             bank0_write_en, bank1_write_en, rw_addr_en, bank_read_sel;
    logic [LOG2N-1:0] read_G_addr, read_H_addr, write_G_addr, write_H_addr;
    logic [LOG2N-2:0] twiddle_addr;
    logic             out_valid;
    logic [LOG2N-1:0] out_index;
    logic             busy, done;

    fft_ctrl #(.BF_LAT(BF_LAT), .LOG2N(LOG2N)) dut (
        .clk(clk), .clear(clear), .start(start), .in_valid(in_valid),
        .load_data_write(load_data_write), .load_data_addr(load_data_addr),
        .bank0_write_en(bank0_write_en), .bank1_write_en(bank1_write_en),
        .rw_addr_en(rw_addr_en), .bank_read_sel(bank_read_sel),
        .read_G_addr(read_G_addr), .read_H_addr(read_H_addr),
        .write_G_addr(write_G_addr), .write_H_addr(write_H_addr),
        .twiddle_addr(twiddle_addr), .out_valid(out_valid), .out_index(out_index),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vin [MAXC];
    int          st  [MAXC];
    int          exp_t [MAXC][NF];
    logic [7:0]  obs_t [MAXC][NF];
    string       fname [NF] = '{"load_write", "load_addr", "read_G", "read_H", "twiddle",
                                "bank0_we", "bank1_we", "rw_addr_en", "write_G", "write_H",
                                "out_valid", "out_index", "busy", "done", "bank_read_sel"};
    int cs, cu, done_c, ncyc;
    int passed, total;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int k = 0; k < LOG2N; k++)
            if (((v >> k) & 1) == 1) r = r + (1 << (LOG2N - 1 - k));
        return r;
    endfunction

    // Build the expected per-cycle timeline. Cycle 0 is the first LOAD cycle.
    // mode 0: contiguous samples, 1: every other cycle, 2: random with pct%.
    task automatic build_model(input int mode, input int pct, input bit noise);
        int k, c, v, r, w, p, g;
        for (int i = 0; i < MAXC; i++) begin
            vin[i] = 0;
            st[i]  = 0;
            for (int f = 0; f < NF; f++) exp_t[i][f] = -1;
            exp_t[i][F_LW] = 0; exp_t[i][F_B0] = 0; exp_t[i][F_B1] = 0; exp_t[i][F_RW] = 0;
            exp_t[i][F_OV] = 0; exp_t[i][F_BUSY] = 0; exp_t[i][F_DONE] = 0;
        end
        k = 0;
        c = 0;
        while (k < N) begin
            case (mode)
                0:       v = 1;
                1:       v = (c % 2 == 0) ? 1 : 0;
                default: v = (int'($urandom_range(99)) < pct || c > 300) ? 1 : 0;
            endcase
            vin[c] = v;
            exp_t[c][F_LW] = v;
            exp_t[c][F_LA] = k;
            k = k + v;
            c = c + 1;
        end
        cs = c;
        for (int s = 0; s < LOG2N; s++) begin
            p = LOG2N - 1 - s;
            for (int t = 0; t < STAGE_LEN; t++) exp_t[cs + s*STAGE_LEN + t][F_BANK] = s % 2;
            for (int b = 0; b < HALF; b++) begin
                r = cs + s*STAGE_LEN + b;
                g = (b / (1 << p)) * (1 << (p + 1)) + (b % (1 << p));
                exp_t[r][F_RG] = g;
                exp_t[r][F_RH] = g + (1 << p);
                exp_t[r][F_TW] = (b * (1 << s)) % HALF;
                w = r + BF_LAT + 1;
                if (s % 2 == 0) exp_t[w][F_B1] = 1;
                else            exp_t[w][F_B0] = 1;
                exp_t[w][F_RW] = 1;
                exp_t[w][F_WG] = g;
                exp_t[w][F_WH] = g + (1 << p);
            end
        end
        cu = cs + LOG2N * STAGE_LEN;
        for (int i = 0; i < N; i++) begin
            exp_t[cu + i][F_RG]     = bitrev(i);
            exp_t[cu + i][F_OI]     = i;
            exp_t[cu + i][F_BANK]   = 1;
            exp_t[cu + i + 1][F_OV] = 1;
        end
        done_c = cu + N;
        exp_t[done_c][F_DONE] = 1;
        for (int i = 0; i < done_c; i++) exp_t[i][F_BUSY] = 1;
        ncyc = done_c + 2;
        if (noise) begin
            for (int i = cs; i < ncyc; i++) vin[i] = int'($urandom_range(1));
            for (int i = 0; i < done_c; i++) st[i] = ($urandom_range(3) == 0) ? 1 : 0;
        end
    endtask

    // Drive one transform from IDLE and record every output each cycle.
    task automatic run_transform(input int mode, input int pct, input bit noise);
        build_model(mode, pct, noise);
        @(posedge clk); #1;
        start    = 1'b1;
        in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = (vin[c] != 0);
            start    = (st[c] != 0);
            @(negedge clk);
            obs_t[c][F_LW]   = {7'd0, load_data_write};
            obs_t[c][F_LA]   = {3'd0, load_data_addr};
            obs_t[c][F_RG]   = {3'd0, read_G_addr};
            obs_t[c][F_RH]   = {3'd0, read_H_addr};
            obs_t[c][F_TW]   = {4'd0, twiddle_addr};
            obs_t[c][F_B0]   = {7'd0, bank0_write_en};
            obs_t[c][F_B1]   = {7'd0, bank1_write_en};
            obs_t[c][F_RW]   = {7'd0, rw_addr_en};
            obs_t[c][F_WG]   = {3'd0, write_G_addr};
            obs_t[c][F_WH]   = {3'd0, write_H_addr};
            obs_t[c][F_OV]   = {7'd0, out_valid};
            obs_t[c][F_OI]   = {3'd0, out_index};
            obs_t[c][F_BUSY] = {7'd0, busy};
            obs_t[c][F_DONE] = {7'd0, done};
            obs_t[c][F_BANK] = {7'd0, bank_read_sel};
            @(posedge clk); #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Full transform compared field by field against the timeline model.
    task automatic test_transform(input string name, input int mode, input int pct, input bit noise);
        run_transform(mode, pct, noise);
        for (int c = 0; c < ncyc; c++)
            for (int f = 0; f < NF; f++)
                if (exp_t[c][f] >= 0) begin
                    total++;
                    if (obs_t[c][f] !== 8'(exp_t[c][f]))
                        $display("FAIL %s.%s cycle %0d: got %0d expected %0d",
                                 name, fname[f], c, obs_t[c][f], exp_t[c][f]);
                    else passed++;
                end
        $display("transform %s: %0d cycles, stage start %0d, unload start %0d", name, ncyc, cs, cu);
    endtask

    task automatic test_reset();
        clear = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({load_data_write, load_data_addr, bank0_write_en, bank1_write_en, rw_addr_en,
             bank_read_sel, read_G_addr, read_H_addr, write_G_addr, write_H_addr,
             twiddle_addr, out_valid, out_index, busy, done} !== 42'd0)
            $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", busy); else passed++;
        clear = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_contiguous_load();
        int dc;
        test_transform("contiguous", 0, 100, 1'b0);
        for (int c = 0; c < N; c++) begin
            total++;
            if (obs_t[c][F_LA] !== 8'(c) || obs_t[c][F_LW] !== 8'd1)
                $display("FAIL contig_load cycle %0d: addr %0d we %0d required addr %0d we 1",
                         c, obs_t[c][F_LA], obs_t[c][F_LW], c);
            else passed++;
        end
        total++;
        if (obs_t[32][F_RH] !== 8'd16 || obs_t[32][F_LW] !== 8'd0)
            $display("FAIL contig_stage_entry: read_H %0d required 16", obs_t[32][F_RH]);
        else passed++;
        dc = -1;
        for (int c = 0; c < ncyc; c++) if (dc < 0 && obs_t[c][F_DONE] === 8'd1) dc = c;
        total++;
        if (dc != 32 + 5*(16 + BF_LAT + 1) + 32)
            $display("FAIL contig_latency: done at cycle %0d required %0d", dc, 32 + 5*(16 + BF_LAT + 1) + 32);
        else passed++;
        total++;
        if (obs_t[130][F_BANK] !== 8'd1)
            $display("FAIL contig_unload_bank: got %0d required 1", obs_t[130][F_BANK]);
        else passed++;
    endtask

    task automatic test_gapped_load();
        int writes;
        test_transform("gapped", 1, 100, 1'b0);
        writes = 0;
        for (int c = 0; c < ncyc; c++) if (obs_t[c][F_LW] === 8'd1) writes++;
        total++;
        if (writes != 32) $display("FAIL gapped_writes: got %0d required 32", writes); else passed++;
        total++;
        if (obs_t[61][F_LA] !== 8'd31 || obs_t[61][F_LW] !== 8'd0 || obs_t[62][F_LA] !== 8'd31)
            $display("FAIL gapped_hold: addr61 %0d addr62 %0d required 31 31", obs_t[61][F_LA], obs_t[62][F_LA]);
        else passed++;
        total++;
        if (obs_t[63][F_RH] !== 8'd16)
            $display("FAIL gapped_stage_entry: read_H %0d required 16", obs_t[63][F_RH]);
        else passed++;
    endtask

    // Uses the gapped capture: stage 2, butterfly 5.
    task automatic test_stage_point();
        int r;
        r = cs + 2*STAGE_LEN + 5;
        total++;
        if (obs_t[r][F_RG] !== 8'd9 || obs_t[r][F_RH] !== 8'd13 || obs_t[r][F_TW] !== 8'd4)
            $display("FAIL stage2_b5_read: G %0d H %0d tw %0d required 9 13 4",
                     obs_t[r][F_RG], obs_t[r][F_RH], obs_t[r][F_TW]);
        else passed++;
        r = r + BF_LAT + 1;
        total++;
        if (obs_t[r][F_B1] !== 8'd1 || obs_t[r][F_B0] !== 8'd0 ||
            obs_t[r][F_WG] !== 8'd9 || obs_t[r][F_WH] !== 8'd13)
            $display("FAIL stage2_b5_write: b1 %0d b0 %0d G %0d H %0d required 1 0 9 13",
                     obs_t[r][F_B1], obs_t[r][F_B0], obs_t[r][F_WG], obs_t[r][F_WH]);
        else passed++;
    endtask

    task automatic test_unload_addressing();
        total++;
        if (obs_t[cu+1][F_OI] !== 8'd1 || obs_t[cu+1][F_RG] !== 8'd16)
            $display("FAIL unload_idx1: index %0d addr %0d required 1 16", obs_t[cu+1][F_OI], obs_t[cu+1][F_RG]);
        else passed++;
        total++;
        if (obs_t[cu+6][F_OI] !== 8'd6 || obs_t[cu+6][F_RG] !== 8'd12)
            $display("FAIL unload_idx6: index %0d addr %0d required 6 12", obs_t[cu+6][F_OI], obs_t[cu+6][F_RG]);
        else passed++;
        total++;
        if (obs_t[cu][F_OV] !== 8'd0 || obs_t[cu+1][F_OV] !== 8'd1)
            $display("FAIL unload_valid_delay: v0 %0d v1 %0d required 0 1", obs_t[cu][F_OV], obs_t[cu+1][F_OV]);
        else passed++;
    endtask

    task automatic test_clear_midstage();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3*STAGE_LEN + 4) @(posedge clk);
        #2;
        total++;
        if (read_G_addr !== 5'd8 || bank0_write_en !== 1'b1 || busy !== 1'b1)
            $display("FAIL clear_precondition: G %0d we0 %0b busy %0b required 8 1 1",
                     read_G_addr, bank0_write_en, busy);
        else passed++;
        clear = 1'b0;
        #1;
        total++;
        if ({load_data_write, load_data_addr, bank0_write_en, bank1_write_en, rw_addr_en,
             bank_read_sel, read_G_addr, read_H_addr, write_G_addr, write_H_addr,
             twiddle_addr, out_valid, out_index, busy, done} !== 42'd0)
            $display("FAIL clear_outputs: got nonzero outputs, required all 0");
        else passed++;
        total++;
        if (bank0_write_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL clear_strobe: we0 %0b busy %0b required 0 0", bank0_write_en, busy);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b1;
        $display("clear: asserted in stage 3 and released");
        test_transform("after_clear", 2, 50, 1'b1);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_contiguous_load();
        test_gapped_load();
        test_stage_point();
        test_unload_addressing();
        test_transform("random_a", 2, 70, 1'b1);
        test_transform("random_b", 2, 35, 1'b1);
        test_clear_midstage();
        test_transform("back_to_back", 0, 100, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
